// File: rtl/msb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : msb_bit_serializer
// Purpose  : Converts parallel words into an MSB-first serial bit stream with
//            start/end-of-frame markers. Intended to feed serial remainder
//            checkers that consume one bit per clock when out_valid is high
//            and clear their remainder on out_sof.
// Ports    : clk        - clock, all logic on posedge
//            reset      - synchronous active-high reset
//            in_valid   - upstream word valid
//            in_ready   - block can accept a word this cycle (from state only)
//            in_data    - word; only the low in_len bits are sent
//            in_len     - number of bits to send, clamped to WIDTH
//            out_bit    - serial data, MSB of the selected field first
//            out_valid  - out_bit is a live bit this cycle
//            out_sof    - first bit of a frame
//            out_eof    - last bit of a frame
//            busy       - block is not idle
// Revision : 1.0  initial release
// ============================================================================
module msb_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    in_len,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy
);

  localparam int            GW        = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [LW-1:0] C_WIDTH_L = LW'(WIDTH);
  localparam logic [GW-1:0] C_GAP_L   = GW'(GAP);
  localparam bit            C_B2B     = (GAP == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state, w_state;
  logic [WIDTH-1:0]   r_shift, w_shift;      // bits still to be shown, left-aligned
  logic [LW-1:0]      r_bits_left, w_bits_left; // includes the bit currently shown
  logic [GW-1:0]      r_gap_cnt, w_gap_cnt;
  logic               r_bit, w_bit;
  logic               r_valid, w_valid;
  logic               r_sof, w_sof;
  logic               r_eof, w_eof;

  logic [LW-1:0]      w_eff_len;
  logic [WIDTH-1:0]   w_aligned;
  logic               w_last;
  logic               w_accept;
  logic               w_load;

  assign w_eff_len = (in_len > C_WIDTH_L) ? C_WIDTH_L : in_len;
  assign w_aligned = in_data << (C_WIDTH_L - w_eff_len);

  // The bit on the outputs is the frame's last one.
  assign w_last    = (r_state == S_SHIFT) && (r_bits_left == LW'(1));

  assign in_ready  = (r_state == S_IDLE) || (C_B2B && w_last);
  assign w_accept  = in_valid && in_ready;
  // Zero-length words are accepted but never start a frame.
  assign w_load    = w_accept && (w_eff_len != '0);

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_bits_left = r_bits_left;
    w_gap_cnt   = r_gap_cnt;
    w_bit       = 1'b0;
    w_valid     = 1'b0;
    w_sof       = 1'b0;
    w_eof       = 1'b0;

    if (w_load) begin
      // Present the first bit right away so sof appears the cycle after accept.
      w_state     = S_SHIFT;
      w_bit       = w_aligned[WIDTH-1];
      w_shift     = w_aligned << 1;
      w_bits_left = w_eff_len;
      w_valid     = 1'b1;
      w_sof       = 1'b1;
      w_eof       = (w_eff_len == LW'(1));
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state = S_IDLE;
        end
        S_SHIFT: begin
          if (!w_last) begin
            w_bit       = r_shift[WIDTH-1];
            w_shift     = r_shift << 1;
            w_bits_left = r_bits_left - LW'(1);
            w_valid     = 1'b1;
            w_eof       = (r_bits_left == LW'(2));
          end else if (C_B2B) begin
            w_state     = S_IDLE;
            w_bits_left = '0;
          end else begin
            w_state     = S_GAP;
            w_bits_left = '0;
            w_gap_cnt   = C_GAP_L;
          end
        end
        S_GAP: begin
          if (r_gap_cnt <= GW'(1)) begin
            w_state   = S_IDLE;
            w_gap_cnt = '0;
          end else begin
            w_gap_cnt = r_gap_cnt - GW'(1);
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_gap_cnt   <= '0;
      r_bit       <= 1'b0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_bits_left <= w_bits_left;
      r_gap_cnt   <= w_gap_cnt;
      r_bit       <= w_bit;
      r_valid     <= w_valid;
      r_sof       <= w_sof;
      r_eof       <= w_eof;
    end
  end

  assign out_bit   = r_bit;
  assign out_valid = r_valid;
  assign out_sof   = r_sof;
  assign out_eof   = r_eof;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_msb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_msb_bit_serializer
// Purpose  : Directed bench for msb_bit_serializer. Instance dut has GAP=0,
//            instance dut_g has GAP=2; both share clock, reset and inputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_msb_bit_serializer;

  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [LW-1:0]    in_len;

  logic in_ready,   out_bit,   out_valid,   out_sof,   out_eof,   busy;
  logic in_ready_g, out_bit_g, out_valid_g, out_sof_g, out_eof_g, busy_g;

  int n_checks = 0;
  int n_pass   = 0;

  msb_bit_serializer #(.WIDTH(WIDTH), .GAP(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy)
  );

  msb_bit_serializer #(.WIDTH(WIDTH), .GAP(2)) dut_g (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_g),
    .in_data   (in_data),
    .in_len    (in_len),
    .out_bit   (out_bit_g),
    .out_valid (out_valid_g),
    .out_sof   (out_sof_g),
    .out_eof   (out_eof_g),
    .busy      (busy_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the GAP=0 instance's serial outputs in one cycle.
  task automatic chk_out(input string tag, input logic v, input logic b,
                         input logic s, input logic e);
    chk({tag, " valid"}, out_valid, v);
    chk({tag, " bit"},   out_bit,   b);
    chk({tag, " sof"},   out_sof,   s);
    chk({tag, " eof"},   out_eof,   e);
  endtask

  // Present one word for exactly one accepting edge (block must be ready).
  task automatic send(input logic [WIDTH-1:0] d, input logic [LW-1:0] l);
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_bits;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    step();
    step();

    // Reset state
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst g in_ready", in_ready_g, 1'b1);
    chk("rst g valid", out_valid_g, 1'b0);
    reset = 1'b0;
    step();

    // 1: A5, full width
    send(8'hA5, 4'd8);
    exp_bits = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("t1 b%0d", i), 1'b1, exp_bits[7-i], (i == 0), (i == 7));
      chk($sformatf("t1 busy%0d", i), busy, 1'b1);
      step();
    end
    chk_out("t1 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1 idle ready", in_ready, 1'b1);
    chk("t1 idle busy", busy, 1'b0);

    // 2: FD, 3 bits -> 101
    send(8'hFD, 4'd3);
    exp_bits = 8'b0000_0101;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("t2 b%0d", i), 1'b1, exp_bits[2-i], (i == 0), (i == 2));
      step();
    end
    chk_out("t2 idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2 idle busy", busy, 1'b0);

    // 3: back-to-back frames with GAP=0, second word held valid
    in_valid = 1'b1;
    in_data  = 8'h0A;
    in_len   = 4'd4;
    step();
    in_data  = 8'h0F;
    exp_bits = 8'b1010_1111;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) in_valid = 1'b0;
      chk_out($sformatf("t3 b%0d", i), 1'b1, exp_bits[7-i],
              (i == 0 || i == 4), (i == 3 || i == 7));
      if (i < 3) chk($sformatf("t3 rdy%0d", i), in_ready, 1'b0);
      if (i == 3) chk("t3 rdy eof", in_ready, 1'b1);
      step();
    end
    chk_out("t3 idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: same two words into the GAP=2 instance
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h0A;
    in_len   = 4'd4;
    step();
    in_data  = 8'h0F;
    exp_bits = 8'b1010_0000;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("t4 v%0d", t), out_valid_g, 1'b1);
      chk($sformatf("t4 b%0d", t), out_bit_g, exp_bits[7-t]);
      chk($sformatf("t4 rdy%0d", t), in_ready_g, 1'b0);
      step();
    end
    for (int t = 4; t < 6; t++) begin
      chk($sformatf("t4 gap v%0d", t), out_valid_g, 1'b0);
      chk($sformatf("t4 gap rdy%0d", t), in_ready_g, 1'b0);
      chk($sformatf("t4 gap busy%0d", t), busy_g, 1'b1);
      step();
    end
    chk("t4 idle v", out_valid_g, 1'b0);
    chk("t4 idle rdy", in_ready_g, 1'b1);
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("t4 f2 v%0d", t), out_valid_g, 1'b1);
      chk($sformatf("t4 f2 b%0d", t), out_bit_g, 1'b1);
      chk($sformatf("t4 f2 sof%0d", t), out_sof_g, (t == 0));
      chk($sformatf("t4 f2 eof%0d", t), out_eof_g, (t == 3));
      step();
    end

    // 5: zero-length word dropped, oversize length clamped
    step();
    step();
    chk("t5 rdy", in_ready, 1'b1);
    send(8'hFF, 4'd0);
    chk_out("t5 zero a", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5 zero busy", busy, 1'b0);
    chk("t5 zero rdy", in_ready, 1'b1);
    step();
    chk("t5 zero b", out_valid, 1'b0);
    send(8'h81, 4'd12);
    exp_bits = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("t5 b%0d", i), 1'b1, exp_bits[7-i], (i == 0), (i == 7));
      step();
    end
    chk_out("t5 idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-frame, then reset together with a valid word
    send(8'hFF, 4'd8);
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("t6 b%0d", i), 1'b1, 1'b1, (i == 0), 1'b0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("t6 abort", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6 abort rdy", in_ready, 1'b1);
    chk("t6 abort busy", busy, 1'b0);
    step();
    chk("t6 abort2 v", out_valid, 1'b0);

    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h81;
    in_len   = 4'd8;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk_out("t6 rstacc a", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t6 rstacc v", out_valid, 1'b0);
    chk("t6 rstacc busy", busy, 1'b0);

    send(8'h02, 4'd2);
    chk_out("t6 new b0", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("t6 new b1", 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("t6 new idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
